// File: rtl/reg_file_rd_pkg.sv
// Shared constants for the ID-stage register file and the RA/RB decode control.
package reg_file_rd_pkg;

  localparam logic [1:0] RSEL_NORM  = 2'b00;
  localparam logic [1:0] RSEL_SYS   = 2'b01;
  localparam logic [1:0] RSEL_SHIFT = 2'b11;

  localparam logic [4:0] REG_V0 = 5'd2;
  localparam logic [4:0] REG_A0 = 5'd4;

  localparam int unsigned SYS_HALT_CODE = 32'd10;
  localparam int unsigned SYS_DISP_CODE = 32'd34;

endpackage

// File: rtl/reg_file_rd_reg_array.sv
// 2-read/1-write register storage with $0 hardwired to zero and write-first bypass.
module reg_file_rd_reg_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  // Storage update; $0 is never written so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_we && (wb_addr != {ADDR_W{1'b0}})) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Port A read with same-cycle write-back forwarding.
  always_comb begin
    rdata_a = {DATA_W{1'b0}};
    if (ra_addr == {ADDR_W{1'b0}}) begin
      rdata_a = {DATA_W{1'b0}};
    end else if (wb_we && (wb_addr == ra_addr)) begin
      rdata_a = wb_data;
    end else begin
      rdata_a = regs[ra_addr];
    end
  end

  // Port B read with same-cycle write-back forwarding.
  always_comb begin
    rdata_b = {DATA_W{1'b0}};
    if (rb_addr == {ADDR_W{1'b0}}) begin
      rdata_b = {DATA_W{1'b0}};
    end else if (wb_we && (wb_addr == rb_addr)) begin
      rdata_b = wb_data;
    end else begin
      rdata_b = regs[rb_addr];
    end
  end

endmodule

// File: rtl/reg_file_rd.sv
// ID-stage register file: read-select steering, WB write with bypass, and
// syscall side effects (halt, display latch, syscall counter).
module reg_file_rd
  import reg_file_rd_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter int unsigned SYS_HALT = SYS_HALT_CODE,
  parameter int unsigned SYS_DISP = SYS_DISP_CODE,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic [1:0]        ra_sel,
  input  logic              id_valid,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] ra_addr,
  output logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              halt,
  output logic [DATA_W-1:0] disp_data,
  output logic [CNT_W-1:0]  sys_cnt
);

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              sys_fire;
  logic              unused_instr_bits;

  assign rs = ADDR_W'(instruction[25:21]);
  assign rt = ADDR_W'(instruction[20:16]);
  assign unused_instr_bits = ^{instruction[31:26], instruction[15:0]};

  // Read-select steering; the reserved 2'b10 encoding falls into the normal path.
  always_comb begin
    ra_addr = rs;
    rb_addr = rt;
    case (ra_sel)
      RSEL_NORM: begin
        ra_addr = rs;
        rb_addr = rt;
      end
      RSEL_SHIFT: begin
        ra_addr = rt;
        rb_addr = rs;
      end
      RSEL_SYS: begin
        ra_addr = ADDR_W'(REG_V0);
        rb_addr = ADDR_W'(REG_A0);
      end
      default: begin
        ra_addr = rs;
        rb_addr = rt;
      end
    endcase
  end

  reg_file_rd_reg_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  assign sys_fire = id_valid && (ra_sel == RSEL_SYS) && !halt;

  // Syscall effects use the bypassed operands, so a same-cycle WB to $v0/$a0 is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt      <= 1'b0;
      disp_data <= {DATA_W{1'b0}};
      sys_cnt   <= {CNT_W{1'b0}};
    end else if (sys_fire) begin
      sys_cnt <= sys_cnt + CNT_W'(1);
      if (rdata_a == DATA_W'(SYS_HALT)) begin
        halt <= 1'b1;
      end else if (rdata_a == DATA_W'(SYS_DISP)) begin
        disp_data <= rdata_b;
      end else begin
        halt <= halt;
      end
    end else begin
      halt <= halt;
    end
  end

endmodule

// File: tb/tb_reg_file_rd.sv
// Directed self-checking bench for reg_file_rd with hand-computed expectations.
module tb_reg_file_rd;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [1:0]  ra_sel;
  logic        id_valid;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        halt;
  logic [31:0] disp_data;
  logic [15:0] sys_cnt;

  int total;
  int bad;

  reg_file_rd dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .ra_sel      (ra_sel),
    .id_valid    (id_valid),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .rdata_a     (rdata_a),
    .rdata_b     (rdata_b),
    .halt        (halt),
    .disp_data   (disp_data),
    .sys_cnt     (sys_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs_rt(input logic [4:0] rs, input logic [4:0] rt);
    instruction = {6'd0, rs, rt, 16'd0};
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wb_we   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_we   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    instruction = 32'd0;
    ra_sel = 2'b00;
    id_valid = 1'b0;
    wb_we = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;

    // 1: asynchronous reset, asserted between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdata_a", rdata_a, 32'd0);
    check("rst_rdata_b", rdata_b, 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_disp", disp_data, 32'd0);
    check("rst_cnt", 32'(sys_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 2: plain write/read and $0 hardwiring
    write_reg(5'd5, 32'h1234);
    set_rs_rt(5'd5, 5'd0);
    ra_sel = 2'b00;
    #1;
    check("rd_a_r5", rdata_a, 32'h1234);
    check("rd_b_r0", rdata_b, 32'd0);
    check("ra_addr_norm", 32'(ra_addr), 32'd5);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    set_rs_rt(5'd0, 5'd5);
    #1;
    check("r0_no_bypass", rdata_a, 32'd0);
    tick();
    wb_we = 1'b0;
    #1;
    check("r0_after_wr", rdata_a, 32'd0);
    check("rd_b_r5", rdata_b, 32'h1234);

    // 3: same-cycle bypass
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hAA;
    set_rs_rt(5'd7, 5'd5);
    #1;
    check("bypass_a", rdata_a, 32'hAA);
    tick();
    wb_we = 1'b0;
    #1;
    check("r7_stored", rdata_a, 32'hAA);

    // 4: shift select swaps ports; reserved 10 behaves like 00
    write_reg(5'd3, 32'h8);
    write_reg(5'd9, 32'h2);
    set_rs_rt(5'd9, 5'd3);
    ra_sel = 2'b11;
    #1;
    check("shift_ra_addr", 32'(ra_addr), 32'd3);
    check("shift_rb_addr", 32'(rb_addr), 32'd9);
    check("shift_a", rdata_a, 32'h8);
    check("shift_b", rdata_b, 32'h2);
    ra_sel = 2'b10;
    #1;
    check("rsvd_ra_addr", 32'(ra_addr), 32'd9);
    check("rsvd_a", rdata_a, 32'h2);

    // 5: display syscall, then id_valid low has no effect
    write_reg(5'd2, 32'd34);
    write_reg(5'd4, 32'hBEEF);
    ra_sel = 2'b01;
    id_valid = 1'b1;
    #1;
    check("sys_ra_addr", 32'(ra_addr), 32'd2);
    check("sys_rb_addr", 32'(rb_addr), 32'd4);
    tick();
    id_valid = 1'b0;
    check("disp_beef", disp_data, 32'hBEEF);
    check("cnt_1", 32'(sys_cnt), 32'd1);
    write_reg(5'd4, 32'h5555);
    tick();
    check("noval_disp", disp_data, 32'hBEEF);
    check("noval_cnt", 32'(sys_cnt), 32'd1);
    // other code counts only
    write_reg(5'd2, 32'd5);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("other_cnt", 32'(sys_cnt), 32'd2);
    check("other_disp", disp_data, 32'hBEEF);
    check("other_halt", 32'(halt), 32'd0);
    // bypassed operands: $v0 from regs, $a0 written in the same cycle
    write_reg(5'd2, 32'd34);
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h77;
    id_valid = 1'b1;
    tick();
    wb_we = 1'b0;
    id_valid = 1'b0;
    check("byp_disp", disp_data, 32'h77);
    check("byp_cnt", 32'(sys_cnt), 32'd3);

    // 6: halt is sticky and blocks further syscalls; writes still land
    write_reg(5'd2, 32'd10);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("halt_set", 32'(halt), 32'd1);
    check("halt_cnt", 32'(sys_cnt), 32'd4);
    write_reg(5'd2, 32'd34);
    write_reg(5'd4, 32'h1111);
    #1;
    check("wr_after_halt", rdata_a, 32'd34);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("halted_disp", disp_data, 32'h77);
    check("halted_cnt", 32'(sys_cnt), 32'd4);
    check("halt_sticky", 32'(halt), 32'd1);

    // reset pulse mid-cycle clears everything
    #2 rst_n = 1'b0;
    #1;
    check("rst2_halt", 32'(halt), 32'd0);
    check("rst2_cnt", 32'(sys_cnt), 32'd0);
    check("rst2_disp", disp_data, 32'd0);
    check("rst2_v0", rdata_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
